// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO for the UART RX/TX <-> host path.
// Each entry is a data word plus its parity bit. It provides an occupancy count,
// FULL/EMPTY, programmable almost-flags, sticky overflow/underflow, a synchronous
// flush, and a choice of registered or show-ahead read.
module fifo_buffer_param #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int AF_LVL     = (2 ** DEPTH_LOG2) - 4,
    parameter int AE_LVL     = 4,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  WR_EN,
    input  logic [DATA_W-1:0]     WR_DATA,
    input  logic                  WR_PARITY,
    input  logic                  RD_EN,
    output logic [DATA_W-1:0]     RD_DATA,
    output logic                  RD_PARITY,
    output logic                  RD_VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    // Almost-full comes out of reset set only when the threshold is zero
    localparam logic          AF_RST  = (AF_LVL <= 0) ? 1'b1 : 1'b0;

    // Entry packing helpers: parity bit sits above the payload
    function automatic logic [DATA_W:0] pack_entry(input logic [DATA_W-1:0] d, input logic p);
        return {p, d};
    endfunction

    function automatic logic [DATA_W-1:0] entry_data(input logic [DATA_W:0] e);
        return e[DATA_W-1:0];
    endfunction

    function automatic logic entry_parity(input logic [DATA_W:0] e);
        return e[DATA_W];
    endfunction

    logic [DATA_W:0]       mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  empty_r, full_r, af_r, ae_r;
    logic                  overflow_r, underflow_r;

    logic                  rd_acc_s, wr_acc_s;
    logic                  ovf_evt_s, unf_evt_s;
    logic [CW-1:0]         count_nxt_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic                  overflow_nxt_s, underflow_nxt_s;

    // Accept decisions, next pointers/count and error events; flush overrides requests
    always_comb begin
        rd_acc_s        = 1'b0;
        wr_acc_s        = 1'b0;
        ovf_evt_s       = 1'b0;
        unf_evt_s       = 1'b0;
        count_nxt_s     = count_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        if (FLUSH) begin
            count_nxt_s  = ZERO_C;
            wr_ptr_nxt_s = {DEPTH_LOG2{1'b0}};
            rd_ptr_nxt_s = {DEPTH_LOG2{1'b0}};
        end else begin
            rd_acc_s  = RD_EN & ~empty_r;
            // A pop in the same cycle frees a slot, so a full FIFO still takes the write
            wr_acc_s  = WR_EN & (~full_r | rd_acc_s);
            ovf_evt_s = WR_EN & full_r & ~rd_acc_s;
            unf_evt_s = RD_EN & empty_r;
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + DEPTH_LOG2'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_nxt_s = rd_ptr_r + DEPTH_LOG2'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_nxt_s = count_r + ONE_C;
                2'b01:   count_nxt_s = count_r - ONE_C;
                default: count_nxt_s = count_r;
            endcase
        end
        // A new error in the same cycle as CLR_ERR keeps the flag set
        overflow_nxt_s  = (overflow_r  & ~CLR_ERR) | ovf_evt_s;
        underflow_nxt_s = (underflow_r & ~CLR_ERR) | unf_evt_s;
    end

    // Pointer, occupancy, flag and sticky-error registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            count_r     <= ZERO_C;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            af_r        <= AF_RST;
            ae_r        <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            empty_r     <= (count_nxt_s == ZERO_C);
            full_r      <= (count_nxt_s == DEPTH_C);
            af_r        <= (count_nxt_s >= AF_C);
            ae_r        <= (count_nxt_s <= AE_C);
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Storage write; the array itself is never reset
    always_ff @(posedge CLK) begin
        if (wr_acc_s && !RST) begin
            mem_r[wr_ptr_r] <= pack_entry(WR_DATA, WR_PARITY);
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            logic [DATA_W:0] head_s;
            assign head_s    = mem_r[rd_ptr_r];
            // Head is masked while empty so the output stays at zero, not stale storage
            assign RD_DATA   = empty_r ? {DATA_W{1'b0}} : entry_data(head_s);
            assign RD_PARITY = empty_r ? 1'b0 : entry_parity(head_s);
            assign RD_VALID  = ~empty_r;
        end else begin : g_registered
            logic [DATA_W-1:0] rd_data_r;
            logic              rd_parity_r;
            logic              rd_valid_r;

            // Registered read port: capture head on pop, data holds otherwise
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rd_data_r   <= {DATA_W{1'b0}};
                    rd_parity_r <= 1'b0;
                    rd_valid_r  <= 1'b0;
                end else if (rd_acc_s) begin
                    rd_data_r   <= entry_data(mem_r[rd_ptr_r]);
                    rd_parity_r <= entry_parity(mem_r[rd_ptr_r]);
                    rd_valid_r  <= 1'b1;
                end else begin
                    rd_valid_r  <= 1'b0;
                end
            end

            assign RD_DATA   = rd_data_r;
            assign RD_PARITY = rd_parity_r;
            assign RD_VALID  = rd_valid_r;
        end
    endgenerate

    assign EMPTY        = empty_r;
    assign FULL         = full_r;
    assign ALMOST_FULL  = af_r;
    assign ALMOST_EMPTY = ae_r;
    assign COUNT        = count_r;
    assign OVERFLOW     = overflow_r;
    assign UNDERFLOW    = underflow_r;

endmodule
